// File: rtl/psdifir_input_pacer.sv
// Input pacer for psdifir_top: buffers stereo samples in a small FIFO and releases them
// to the FIR at a fixed sample rate, one outstanding handshake at a time.
module psdifir_input_pacer #(
    parameter int unsigned DATA_WIDTH  = 18,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 3,
    parameter int unsigned SAMPLE_DIV  = 2083,
    parameter int unsigned FIR_TIMEOUT = 2048
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_left,
    input  logic [DATA_WIDTH-1:0] src_right,
    output logic [DATA_WIDTH-1:0] fir_left,
    output logic [DATA_WIDTH-1:0] fir_right,
    output logic                  fir_datain_ready,
    input  logic                  fir_dataout_ready,
    input  logic                  clear_flags,
    output logic [ADDR_WIDTH:0]   fifo_level,
    output logic                  overrun,
    output logic                  underrun,
    output logic                  deadline_miss,
    output logic                  fir_timeout
);

    localparam int unsigned TickW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned WaitW = (FIR_TIMEOUT > 1) ? $clog2(FIR_TIMEOUT) : 1;
    localparam int unsigned WordW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e                state_q;
    logic [TickW-1:0]      tick_cnt_q;
    logic                  tick_pending_q;
    logic [WaitW-1:0]      wait_cnt_q;
    logic                  dout_prev_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [WordW-1:0]      mem_q [FIFO_DEPTH];

    logic tick;
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic starve;
    logic push;
    logic drop;
    logic fir_rise;
    logic wait_expired;
    logic timeout_ev;
    logic [WordW-1:0] rd_word;

    always_comb begin
        tick         = (tick_cnt_q == TickW'(SAMPLE_DIV - 1));
        fifo_full    = (fifo_level == (ADDR_WIDTH + 1)'(FIFO_DEPTH));
        fifo_empty   = (fifo_level == '0);
        pop          = (state_q == StIdle) && tick_pending_q && !fifo_empty;
        starve       = (state_q == StIdle) && tick_pending_q && fifo_empty;
        // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
        push         = src_valid && (!fifo_full || pop);
        drop         = src_valid && fifo_full && !pop;
        fir_rise     = fir_dataout_ready && !dout_prev_q;
        wait_expired = (wait_cnt_q == WaitW'(FIR_TIMEOUT - 1));
        timeout_ev   = (state_q == StWait) && !fir_rise && wait_expired;
        rd_word      = mem_q[rd_ptr_q];
    end

    // Storage is not reset; the pointers and level alone define its contents.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {src_left, src_right};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_cnt_q     <= '0;
            tick_pending_q <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_level     <= '0;
            dout_prev_q    <= 1'b0;
        end else begin
            tick_cnt_q  <= tick ? '0 : tick_cnt_q + TickW'(1);
            dout_prev_q <= fir_dataout_ready;
            if (tick) begin
                tick_pending_q <= 1'b1;
            end else if (pop || starve) begin
                tick_pending_q <= 1'b0;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + (ADDR_WIDTH + 1)'(1);
            end else if (pop && !push) begin
                fifo_level <= fifo_level - (ADDR_WIDTH + 1)'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= StIdle;
            wait_cnt_q       <= '0;
            fir_left         <= '0;
            fir_right        <= '0;
            fir_datain_ready <= 1'b0;
        end else begin
            fir_datain_ready <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        fir_left         <= rd_word[WordW-1:DATA_WIDTH];
                        fir_right        <= rd_word[DATA_WIDTH-1:0];
                        fir_datain_ready <= 1'b1;
                        state_q          <= StIssue;
                    end
                end
                StIssue: begin
                    wait_cnt_q <= '0;
                    state_q    <= StWait;
                end
                StWait: begin
                    if (fir_rise || wait_expired) begin
                        state_q <= StIdle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WaitW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Set events take priority over a concurrent clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overrun       <= 1'b0;
            underrun      <= 1'b0;
            deadline_miss <= 1'b0;
            fir_timeout   <= 1'b0;
        end else begin
            overrun       <= drop                     | (overrun       & ~clear_flags);
            underrun      <= starve                   | (underrun      & ~clear_flags);
            deadline_miss <= (tick && tick_pending_q) | (deadline_miss & ~clear_flags);
            fir_timeout   <= timeout_ev               | (fir_timeout   & ~clear_flags);
        end
    end

endmodule
